// File: rtl/ana_bellek_if.sv
// CPU memory port and boot-loader port of the main memory, grouped as one bus.
// The CPU side drives addresses and data; the memory side returns read data and status.
interface ana_bellek_if #(
   parameter int unsigned ADRES_BIT  = 32,
   parameter int unsigned VERI_BIT   = 32,
   parameter int unsigned INDEKS_BIT = 10
);
   logic [ADRES_BIT-1:0]  bellek_adres;
   logic [VERI_BIT-1:0]   bellek_yaz_veri;
   logic                  bellek_yaz;
   logic [VERI_BIT-1:0]   bellek_oku_veri;
   logic                  yukle_gecerli;
   logic [INDEKS_BIT-1:0] yukle_indeks;
   logic [VERI_BIT-1:0]   yukle_veri;
   logic                  hata;
   logic [ADRES_BIT-1:0]  hata_adres;
   logic [15:0]           yazma_sayaci;

   modport master (
      output bellek_adres, bellek_yaz_veri, bellek_yaz,
      output yukle_gecerli, yukle_indeks, yukle_veri,
      input  bellek_oku_veri, hata, hata_adres, yazma_sayaci
   );

   modport slave (
      input  bellek_adres, bellek_yaz_veri, bellek_yaz,
      input  yukle_gecerli, yukle_indeks, yukle_veri,
      output bellek_oku_veri, hata, hata_adres, yazma_sayaci
   );
endinterface

// File: rtl/ana_bellek.sv
// Word-addressed main memory behind a base-address window: registered write-first
// reads, synchronous CPU and loader writes, sticky illegal-access capture.
module ana_bellek #(
   parameter int unsigned          ADRES_BIT       = 32,
   parameter logic [ADRES_BIT-1:0] BASLANGIC_ADRES = 32'h8000_0000,
   parameter int unsigned          KELIME_SAYISI   = 1024,
   parameter int unsigned          VERI_BIT        = 32
) (
   input  logic        clk,
   input  logic        rst,
   ana_bellek_if.slave bus
);
   localparam int unsigned INDEKS_BIT = $clog2(KELIME_SAYISI);

   logic [VERI_BIT-1:0]   r_mem [KELIME_SAYISI];
   logic [VERI_BIT-1:0]   r_oku;
   logic                  r_hata;
   logic [ADRES_BIT-1:0]  r_hata_adres;
   logic [15:0]           r_sayac;

   logic [ADRES_BIT-1:0]  w_ofset;
   logic                  w_gecerli;
   logic [INDEKS_BIT-1:0] w_indeks;
   logic                  w_cpu_yaz;
   logic                  w_yaz_en;
   logic [INDEKS_BIT-1:0] w_yaz_indeks;
   logic [VERI_BIT-1:0]   w_yaz_veri;
   logic                  w_bypass;

   // The window size is a power of two, so "below the top" means no offset bits above the index.
   always_comb begin
      w_ofset      = bus.bellek_adres - BASLANGIC_ADRES;
      w_gecerli    = (bus.bellek_adres >= BASLANGIC_ADRES)
                     && ((w_ofset >> (INDEKS_BIT + 2)) == '0)
                     && (bus.bellek_adres[1:0] == 2'b00);
      w_indeks     = INDEKS_BIT'(w_ofset >> 2);
      w_cpu_yaz    = bus.bellek_yaz && w_gecerli && !bus.yukle_gecerli;
      w_yaz_en     = bus.yukle_gecerli || w_cpu_yaz;
      w_yaz_indeks = bus.yukle_gecerli ? bus.yukle_indeks : w_indeks;
      w_yaz_veri   = bus.yukle_gecerli ? bus.yukle_veri   : bus.bellek_yaz_veri;
      w_bypass     = w_yaz_en && (w_yaz_indeks == w_indeks);
   end

   always_ff @(posedge clk) begin
      if (w_yaz_en) begin
         r_mem[w_yaz_indeks] <= w_yaz_veri;
      end
   end

   // Write-first: a read of the word being written this cycle returns the new data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_oku <= '0;
      end else if (!w_gecerli) begin
         r_oku <= '0;
      end else if (w_bypass) begin
         r_oku <= w_yaz_veri;
      end else begin
         r_oku <= r_mem[w_indeks];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hata       <= 1'b0;
         r_hata_adres <= '0;
      end else if (!w_gecerli && !r_hata) begin
         r_hata       <= 1'b1;
         r_hata_adres <= bus.bellek_adres;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sayac <= '0;
      end else if (w_cpu_yaz && (r_sayac != 16'hFFFF)) begin
         r_sayac <= r_sayac + 16'd1;
      end
   end

   assign bus.bellek_oku_veri = r_oku;
   assign bus.hata            = r_hata;
   assign bus.hata_adres      = r_hata_adres;
   assign bus.yazma_sayaci    = r_sayac;
endmodule
